multi_dice: RTL

Parametrised electronic dice bank, the successor to the single six-sided dice. It rolls N_DICE dice of FACES faces each, chained as an odometer, while the button is held. Individual dice can be frozen with a per-die hold mask. On button release it publishes the registered total with a one-cycle valid pulse. It sits between a debounced push-button and the display/scoring logic.

---
 rtl/multi_dice.sv | 101 ++++++++++
 1 files changed

// File: rtl/multi_dice.sv
// Electronic dice bank: N_DICE odometer-chained dice that roll while the button is held,
// with per-die hold and a registered total published on release with a one-cycle valid pulse.
module multi_dice #(
  parameter int unsigned N_DICE = 2,
  parameter int unsigned FACES  = 6,
  localparam int unsigned W     = $clog2(FACES + 1),
  localparam int unsigned SW    = $clog2(N_DICE * FACES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  input  logic [N_DICE-1:0]     hold,
  output logic [N_DICE*W-1:0]   throw,
  output logic [SW-1:0]         total,
  output logic                  valid,
  output logic                  rolling
);

  typedef enum logic [1:0] {
    StIdle,
    StRoll,
    StResult
  } state_e;

  state_e                     state_q, state_d;
  logic [N_DICE-1:0][W-1:0]   dice_q, dice_d;
  logic [SW-1:0]              total_q, total_d;
  logic [SW-1:0]              sum;

  // Odometer chain: held dice pass the carry through, out-of-range dice reload 1.
  always_comb begin
    logic         carry;
    logic [W-1:0] v;
    carry  = 1'b1;
    dice_d = dice_q;
    for (int k = 0; k < int'(N_DICE); k++) begin
      v = dice_q[k];
      if (v == '0 || v > W'(FACES)) begin
        dice_d[k] = W'(1);
        carry     = 1'b0;
      end else if (hold[k]) begin
        dice_d[k] = v;
      end else if (button && carry) begin
        if (v == W'(FACES)) begin
          dice_d[k] = W'(1);
        end else begin
          dice_d[k] = v + W'(1);
          carry     = 1'b0;
        end
      end else begin
        dice_d[k] = v;
        carry     = 1'b0;
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < int'(N_DICE); k++) begin
      sum = sum + SW'(dice_q[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    unique case (state_q)
      StIdle: begin
        if (button) state_d = StRoll;
      end
      StRoll: begin
        if (!button) begin
          state_d = StResult;
          total_d = sum;
        end
      end
      StResult: begin
        state_d = button ? StRoll : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      dice_q  <= {N_DICE{W'(1)}};
      total_q <= '0;
    end else begin
      state_q <= state_d;
      dice_q  <= dice_d;
      total_q <= total_d;
    end
  end

  assign throw   = dice_q;
  assign total   = total_q;
  assign valid   = (state_q == StResult);
  assign rolling = (state_q == StRoll);

endmodule
